// File: rtl/pacman_mover.sv
// Pacman movement engine: latches button requests, scans the 21-entry wall map for
// each move_tick, and steps the 26x26 sprite one pixel when the path is clear.
module pacman_mover (
    input  logic        clk,
    input  logic        reset,
    input  logic        move_tick,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        kill_pac,
    input  logic [37:0] curr_rect,
    output logic [4:0]  rect_addr,
    output logic [9:0]  pacman_left_x,
    output logic [8:0]  pacman_top_y,
    output logic [18:0] pacman_top_left,
    output logic [18:0] pacman_bottom_right,
    output logic [2:0]  dir,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic        busy,
    output logic [1:0]  fsm_state
);
    // Handshake: move_tick is a one-cycle request strobe that is accepted only in
    // S_IDLE with game_over low; while busy is high a strobe is dropped, never queued.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_MOVE = 2'd2
    } state_t;

    localparam logic [2:0] D_NONE  = 3'd0;
    localparam logic [2:0] D_UP    = 3'd1;
    localparam logic [2:0] D_DOWN  = 3'd2;
    localparam logic [2:0] D_LEFT  = 3'd3;
    localparam logic [2:0] D_RIGHT = 3'd4;

    localparam logic [9:0] SPAWN_X = 10'd307;
    localparam logic [8:0] SPAWN_Y = 9'd355;
    localparam logic [4:0] LAST_I  = 5'd21;

    state_t      state;
    logic [4:0]  i;
    logic [2:0]  want_dir;
    logic [2:0]  want_dir_s;
    logic        kill_prev;
    logic        kill_edge;
    logic signed [11:0] want_cx, want_cy, cur_cx, cur_cy;
    logic        want_ok, cur_ok;
    logic signed [11:0] want_nx, want_ny, cur_nx, cur_ny;
    logic signed [11:0] pos_xs, pos_ys;

    function automatic logic signed [11:0] step_x(input logic [2:0] d);
        if (d == D_LEFT)       return -12'sd1;
        else if (d == D_RIGHT) return 12'sd1;
        else                   return 12'sd0;
    endfunction

    function automatic logic signed [11:0] step_y(input logic [2:0] d);
        if (d == D_UP)        return -12'sd1;
        else if (d == D_DOWN) return 12'sd1;
        else                  return 12'sd0;
    endfunction

    function automatic logic on_screen(input logic signed [11:0] cx,
                                       input logic signed [11:0] cy);
        return (cx >= 12'sd0) && (cy >= 12'sd0) &&
               (cx + 12'sd25 <= 12'sd639) && (cy + 12'sd25 <= 12'sd479);
    endfunction

    // Inclusive overlap of the 26x26 candidate box against one wall rectangle.
    function automatic logic hits(input logic signed [11:0] cx,
                                  input logic signed [11:0] cy,
                                  input logic [37:0] r);
        logic signed [11:0] rx0, ry0, rx1, ry1;
        rx0 = $signed({2'b00, r[37:28]});
        ry0 = $signed({3'b000, r[27:19]});
        rx1 = $signed({2'b00, r[18:9]});
        ry1 = $signed({3'b000, r[8:0]});
        return (cx <= rx1) && (cx + 12'sd25 >= rx0) &&
               (cy <= ry1) && (cy + 12'sd25 >= ry0);
    endfunction

    always_comb begin
        pos_xs  = $signed({2'b00, pacman_left_x});
        pos_ys  = $signed({3'b000, pacman_top_y});
        want_nx = pos_xs + step_x(want_dir);
        want_ny = pos_ys + step_y(want_dir);
        cur_nx  = pos_xs + step_x(dir);
        cur_ny  = pos_ys + step_y(dir);
    end

    assign kill_edge           = kill_pac & ~kill_prev;
    assign rect_addr           = (i > 5'd20) ? 5'd20 : i;
    assign pacman_top_left     = {pacman_left_x, pacman_top_y};
    assign pacman_bottom_right = {pacman_left_x + 10'd25, pacman_top_y + 9'd25};
    assign game_over           = (lives == 2'd0);
    assign busy                = (state != S_IDLE);
    assign fsm_state           = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            i             <= 5'd0;
            want_dir      <= D_NONE;
            want_dir_s    <= D_NONE;
            dir           <= D_NONE;
            lives         <= 2'd3;
            kill_prev     <= 1'b0;
            pacman_left_x <= SPAWN_X;
            pacman_top_y  <= SPAWN_Y;
            want_cx       <= 12'sd0;
            want_cy       <= 12'sd0;
            cur_cx        <= 12'sd0;
            cur_cy        <= 12'sd0;
            want_ok       <= 1'b0;
            cur_ok        <= 1'b0;
        end else begin
            kill_prev <= kill_pac;
            if (kill_edge) begin
                lives         <= (lives == 2'd0) ? 2'd0 : lives - 2'd1;
                pacman_left_x <= SPAWN_X;
                pacman_top_y  <= SPAWN_Y;
                dir           <= D_NONE;
                want_dir      <= D_NONE;
                state         <= S_IDLE;
                i             <= 5'd0;
            end else begin
                if (btn_up)         want_dir <= D_UP;
                else if (btn_down)  want_dir <= D_DOWN;
                else if (btn_left)  want_dir <= D_LEFT;
                else if (btn_right) want_dir <= D_RIGHT;

                case (state)
                    S_IDLE: begin
                        if (move_tick && !game_over) begin
                            state      <= S_SCAN;
                            i          <= 5'd0;
                            want_dir_s <= want_dir;
                            want_cx    <= want_nx;
                            want_cy    <= want_ny;
                            cur_cx     <= cur_nx;
                            cur_cy     <= cur_ny;
                            // Off-screen candidates and "no direction" start out blocked.
                            want_ok    <= (want_dir != D_NONE) && on_screen(want_nx, want_ny);
                            cur_ok     <= (dir != D_NONE) && on_screen(cur_nx, cur_ny);
                        end
                    end
                    S_SCAN: begin
                        // Read data lags the address by one cycle, so i=0 has nothing to check.
                        if (i != 5'd0) begin
                            want_ok <= want_ok & ~hits(want_cx, want_cy, curr_rect);
                            cur_ok  <= cur_ok & ~hits(cur_cx, cur_cy, curr_rect);
                        end
                        if (i == LAST_I) begin
                            state <= S_MOVE;
                            i     <= 5'd0;
                        end else begin
                            i <= i + 5'd1;
                        end
                    end
                    S_MOVE: begin
                        if (want_ok) begin
                            pacman_left_x <= want_cx[9:0];
                            pacman_top_y  <= want_cy[8:0];
                            dir           <= want_dir_s;
                        end else if (cur_ok) begin
                            pacman_left_x <= cur_cx[9:0];
                            pacman_top_y  <= cur_cy[8:0];
                        end else begin
                            dir <= D_NONE;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pacman_mover.sv
// Directed bench for pacman_mover: synchronous map ROM model, hand-computed
// expectations for free moves, wall/edge blocking, kills, dropped ticks and reset.
module tb_pacman_mover;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        move_tick = 1'b0;
    logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic        kill_pac = 1'b0;
    logic [37:0] curr_rect = '0;
    logic [4:0]  rect_addr;
    logic [9:0]  pacman_left_x;
    logic [8:0]  pacman_top_y;
    logic [18:0] pacman_top_left, pacman_bottom_right;
    logic [2:0]  dir;
    logic [1:0]  lives;
    logic        game_over, busy;
    logic [1:0]  fsm_state;

    logic [37:0] rom [0:20];
    int n_cmp  = 0;
    int n_fail = 0;

    pacman_mover dut (
        .clk                 (clk),
        .reset               (reset),
        .move_tick           (move_tick),
        .btn_up              (btn_up),
        .btn_down            (btn_down),
        .btn_left            (btn_left),
        .btn_right           (btn_right),
        .kill_pac            (kill_pac),
        .curr_rect           (curr_rect),
        .rect_addr           (rect_addr),
        .pacman_left_x       (pacman_left_x),
        .pacman_top_y        (pacman_top_y),
        .pacman_top_left     (pacman_top_left),
        .pacman_bottom_right (pacman_bottom_right),
        .dir                 (dir),
        .lives               (lives),
        .game_over           (game_over),
        .busy                (busy),
        .fsm_state           (fsm_state)
    );

    // Clock and synchronous map ROM: data valid one cycle after the address.
    always #5 clk = ~clk;
    always @(posedge clk) curr_rect <= rom[rect_addr];

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [37:0] make_rect(input int x0, input int y0,
                                              input int x1, input int y1);
        logic [9:0] a;
        logic [8:0] b;
        logic [9:0] c;
        logic [8:0] d;
        a = 10'(x0); b = 9'(y0); c = 10'(x1); d = 9'(y1);
        return {a, b, c, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int k = 0; k < 21; k++) rom[k] = make_rect(630, 470, 639, 479);
    endtask

    task automatic press(input logic u, input logic d, input logic l, input logic r);
        @(negedge clk);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    endtask

    task automatic tick_plain();
        @(negedge clk); move_tick = 1'b1;
        @(negedge clk); move_tick = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic tick_checked(input string tag);
        @(negedge clk); move_tick = 1'b1;
        @(negedge clk); move_tick = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        repeat (22) @(negedge clk);
        check({tag, "_busy_move_cycle"}, busy, 1);
        @(negedge clk);
        check({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        clear_rom();
        repeat (3) @(negedge clk);
        check("reset_x", pacman_left_x, 307);
        check("reset_y", pacman_top_y, 355);
        check("reset_top_left", pacman_top_left, {10'd307, 9'd355});
        check("reset_bottom_right", pacman_bottom_right, {10'd332, 9'd380});
        check("reset_dir", dir, 0);
        check("reset_lives", lives, 3);
        check("reset_game_over", game_over, 0);
        check("reset_busy", busy, 0);
        check("reset_rect_addr", rect_addr, 0);
        reset = 1'b0;

        // Free move right from spawn.
        press(0, 0, 0, 1);
        tick_checked("free");
        check("free_x", pacman_left_x, 308);
        check("free_y", pacman_top_y, 355);
        check("free_dir", dir, 4);

        // Want up blocked by a wall just above (first ROM entry); keep going right.
        rom[0] = make_rect(300, 300, 400, 354);
        btn_up = 1'b1;
        tick_checked("blocked_want");
        btn_up = 1'b0;
        check("blocked_want_x", pacman_left_x, 309);
        check("blocked_want_y", pacman_top_y, 355);
        check("blocked_want_dir", dir, 4);

        // Wall immediately right in the last ROM entry: stop.
        rom[20] = make_rect(335, 300, 345, 400);
        tick_checked("wall");
        check("wall_x", pacman_left_x, 309);
        check("wall_y", pacman_top_y, 355);
        check("wall_dir", dir, 0);

        // Turn left away from both walls.
        press(0, 0, 1, 0);
        tick_checked("turn_left");
        check("turn_left_x", pacman_left_x, 308);
        check("turn_left_dir", dir, 3);

        // Travel to (0,100) and try to move off the left edge.
        clear_rom();
        press(1, 0, 0, 0);
        for (int k = 0; k < 255; k++) tick_plain();
        check("travel_up_y", pacman_top_y, 100);
        check("travel_up_dir", dir, 1);
        press(0, 0, 1, 0);
        for (int k = 0; k < 308; k++) tick_plain();
        check("travel_left_x", pacman_left_x, 0);
        tick_checked("edge");
        check("edge_x", pacman_left_x, 0);
        check("edge_y", pacman_top_y, 100);
        check("edge_dir", dir, 0);

        // Second tick during a scan is dropped.
        press(0, 0, 0, 1);
        @(negedge clk); move_tick = 1'b1;
        @(negedge clk); move_tick = 1'b0;
        repeat (5) @(negedge clk);
        move_tick = 1'b1;
        @(negedge clk); move_tick = 1'b0;
        repeat (40) @(negedge clk);
        check("drop_tick_x", pacman_left_x, 1);
        check("drop_tick_dir", dir, 4);
        check("drop_tick_busy", busy, 0);

        // Reset in the middle of a scan.
        @(negedge clk); move_tick = 1'b1;
        @(negedge clk); move_tick = 1'b0;
        repeat (8) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midreset_x", pacman_left_x, 307);
        check("midreset_y", pacman_top_y, 355);
        check("midreset_dir", dir, 0);
        check("midreset_lives", lives, 3);
        check("midreset_busy", busy, 0);
        check("midreset_rect_addr", rect_addr, 0);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("midreset_no_move_x", pacman_left_x, 307);

        // Kill in scan cycle 10, held 50 cycles.
        press(0, 0, 0, 1);
        tick_checked("prekill");
        check("prekill_x", pacman_left_x, 308);
        @(negedge clk); move_tick = 1'b1;
        @(negedge clk); move_tick = 1'b0;
        repeat (10) @(negedge clk);
        kill_pac = 1'b1;
        @(negedge clk);
        check("kill_x", pacman_left_x, 307);
        check("kill_y", pacman_top_y, 355);
        check("kill_state", fsm_state, 0);
        check("kill_busy", busy, 0);
        check("kill_dir", dir, 0);
        check("kill_lives", lives, 2);
        repeat (49) @(negedge clk);
        kill_pac = 1'b0;
        check("kill_hold_lives", lives, 2);
        check("kill_hold_x", pacman_left_x, 307);

        // Kill and tick together: kill wins.
        press(0, 0, 0, 1);
        kill_pac = 1'b1; move_tick = 1'b1;
        @(negedge clk); kill_pac = 1'b0; move_tick = 1'b0;
        check("kill_tick_lives", lives, 1);
        check("kill_tick_busy", busy, 0);
        repeat (30) @(negedge clk);
        check("kill_tick_x", pacman_left_x, 307);

        @(negedge clk); kill_pac = 1'b1;
        @(negedge clk); kill_pac = 1'b0;
        check("last_kill_lives", lives, 0);
        check("last_kill_game_over", game_over, 1);

        // Ticks ignored once the game is over; lives saturate.
        press(0, 0, 0, 1);
        @(negedge clk); move_tick = 1'b1;
        @(negedge clk); move_tick = 1'b0;
        check("over_tick_busy", busy, 0);
        repeat (30) @(negedge clk);
        check("over_tick_x", pacman_left_x, 307);
        check("over_tick_y", pacman_top_y, 355);
        @(negedge clk); kill_pac = 1'b1;
        @(negedge clk); kill_pac = 1'b0;
        check("over_kill_lives", lives, 0);
        check("over_kill_game_over", game_over, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pacman_mover.md
PACMAN_MOVER -- requirements
Module: pacman_mover

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  system clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high; forces the REQ-030 state.
REQ-004 move_tick  in  1  one-cycle strobe; requests one movement step.
REQ-005 btn_up, btn_down, btn_left, btn_right  in  1 each  active-high direction requests.
REQ-006 kill_pac  in  1  level from the ghost stage; high while the ghost overlaps pacman.
REQ-007 curr_rect  in  38  wall rectangle {x0[37:28], y0[27:19], x1[18:9], y1[8:0]}, inclusive; map ROM read data, valid one cycle after rect_addr.
REQ-008 rect_addr  out  5  map ROM address, 0..20.
REQ-009 pacman_left_x  out  10  sprite left x.
REQ-010 pacman_top_y  out  9  sprite top y.
REQ-011 pacman_top_left, pacman_bottom_right  out  19 each  {x,y} and {x+25,y+25}.
REQ-012 dir  out  3  current direction: 0 none, 1 up, 2 down, 3 left, 4 right.
REQ-013 lives  out  2  remaining lives.
REQ-014 game_over  out  1  high when lives = 0.
REQ-015 busy  out  1  high in S_SCAN and S_MOVE.

Function
REQ-016 The sprite SHALL be 26x26 pixels; screen bounds x 0..639, y 0..479.
REQ-017 Button priority SHALL be up > down > left > right; a pressed button SHALL be latched into want_dir every cycle. want_dir SHALL hold while no button is pressed.
REQ-018 The FSM SHALL have 3 states: S_IDLE, S_SCAN, S_MOVE.
REQ-019 S_IDLE -> S_SCAN on move_tick when game_over=0; otherwise S_IDLE holds.
REQ-020 The S_SCAN counter i SHALL run from 0 to 21, with rect_addr = min(i,20). In cycle i >= 1, curr_rect for address i-1 SHALL be evaluated. S_SCAN SHALL last exactly 22 cycles, then S_MOVE for 1 cycle, then S_IDLE. move_tick to S_IDLE latency SHALL be 24 cycles.
REQ-021 On scan entry, the want candidate (pos + unit step of want_dir) and the cur candidate (pos + step of dir) SHALL be frozen, with both ok flags set to 1.
REQ-022 A candidate SHALL be blocked when its 26x26 box overlaps any rect on both axes, inclusive (cx <= x1, cx+25 >= x0, cy <= y1, cy+25 >= y0).
REQ-023 A candidate SHALL also be blocked when it is out of screen: cx < 0, cy < 0, cx+25 > 639, or cy+25 > 479.
REQ-024 Candidate arithmetic SHALL be signed 12-bit, so that x=0 moving left never wraps.
REQ-025 Direction 0 (none) SHALL never be ok.
REQ-026 In S_MOVE: if want ok, pos <= want candidate and dir <= want_dir; else if cur ok, pos <= cur candidate; else pos holds and dir <= 0.
REQ-027 move_tick while busy SHALL be dropped, not queued.
REQ-028 A rising edge of kill_pac (registered previous value 0, current value 1), in any state, SHALL take effect next cycle as follows:
- lives decrements, saturating at 0;
- pos <= spawn (307,355); dir <= 0, want_dir <= 0;
- FSM <= S_IDLE, i <= 0, and any in-flight scan is discarded.
REQ-029 kill_pac held high SHALL cost exactly one life. A kill edge and move_tick in the same cycle: the kill wins and the tick is dropped. game_over SHALL equal (lives == 0); while game_over is high, position stays frozen at spawn.

Reset
REQ-030 When reset is high, the following SHALL be forced:
- pacman_left_x = 307, pacman_top_y = 355;
- dir = 0, want_dir = 0, lives = 3, game_over = 0;
- FSM = S_IDLE, busy = 0, i = 0, rect_addr = 0;
- kill_pac edge register = 0.
REQ-031 Reset SHALL take priority over kill_pac and move_tick, and SHALL abort a scan mid-operation.

Verification
REQ-032 Free move: ROM with no rect touching the spawn neighbourhood, btn_right pulse, move_tick -> after 24 cycles pacman_left_x = 308, dir = 4, busy low.
REQ-033 Blocked want with cur continuing: dir = 4, rect at (300,300)-(400,354) directly above the sprite, hold btn_up, tick -> x+1, y unchanged, dir stays 4.
REQ-034 Wall stop: a rect with x0 = pacman_left_x + 26 directly right, dir = 4, no buttons, tick -> position unchanged, dir = 0.
REQ-035 Screen edge: position (0,100), want left, tick -> x stays 0 with no wrap to 1023, dir = 0.
REQ-036 Kill mid-scan: tick, then raise kill_pac in scan cycle 10 and hold it 50 cycles -> next cycle pos = (307,355), FSM S_IDLE, lives 3->2 once only; three separate kill pulses -> lives = 0, game_over = 1, later ticks ignored.
REQ-037 Tick while busy: a second move_tick during S_SCAN -> exactly one step of movement; reset asserted mid-scan -> REQ-030 values on the next cycle.
